// File: rtl/prim_arb_pkg.sv
// Shared types and the wrap-around priority scan for the round-robin arbiter.
package prim_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

    // Largest requester count the scan function supports.
    localparam int unsigned ARB_MAX_N = 32;
    localparam int unsigned ARB_IDX_W = 5;

    // First set bit of req scanning ptr, ptr+1, ... wrapping at n-1 -> 0; returns ptr if none set.
    function automatic logic [ARB_IDX_W-1:0] rr_pick(
        input logic [ARB_MAX_N-1:0] req,
        input logic [ARB_IDX_W-1:0] ptr,
        input logic [ARB_IDX_W:0]   n
    );
        logic [ARB_IDX_W-1:0] pick;
        logic [ARB_IDX_W:0]   idx;
        logic                 found;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < ARB_MAX_N; k++) begin
            idx = {1'b0, ptr} + (ARB_IDX_W + 1)'(k);
            if (idx >= n) begin
                idx = idx - n;
            end
            if (!found && (k < 32'(n)) && req[idx[ARB_IDX_W-1:0]]) begin
                pick  = idx[ARB_IDX_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/prim_arb_rr_if.sv
// Bundle of the upstream request lanes and the downstream channel of prim_arb_rr.
interface prim_arb_rr_if #(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]       en_i;
    logic [N-1:0]       uvld_i;
    logic [N*WIDTH-1:0] udat_i;
    logic [N-1:0]       ulast_i;
    logic [N-1:0]       urdy_o;
    logic               dstall_i;
    logic               drdy_i;
    logic               dvld_o;
    logic [WIDTH-1:0]   ddat_o;
    logic               dlast_o;
    logic [IDW-1:0]     dsel_o;

    // Producer/consumer side.
    modport master (
        output en_i, uvld_i, udat_i, ulast_i, dstall_i, drdy_i,
        input  urdy_o, dvld_o, ddat_o, dlast_o, dsel_o
    );

    // Arbiter side.
    modport slave (
        input  en_i, uvld_i, udat_i, ulast_i, dstall_i, drdy_i,
        output urdy_o, dvld_o, ddat_o, dlast_o, dsel_o
    );
endinterface

// File: rtl/prim_skidbuf.sv
// Two-entry valid/ready skid buffer with registered ready; stall blocks the output side.
module prim_skidbuf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             uvld,
    input  logic [WIDTH-1:0] udat,
    output logic             urdy,
    output logic             dvld,
    output logic [WIDTH-1:0] ddat,
    input  logic             drdy
);
    logic             out_vld_q;
    logic             skid_vld_q;
    logic [WIDTH-1:0] out_dat_q;
    logic [WIDTH-1:0] skid_dat_q;
    logic             push;
    logic             pop;
    logic             load_out;

    // Ready and valid are forced low while reset is held so nothing moves.
    assign urdy     = !skid_vld_q && !reset;
    assign dvld     = out_vld_q && !stall && !reset;
    assign ddat     = out_dat_q;
    assign push     = uvld && urdy;
    assign pop      = dvld && drdy;
    assign load_out = !out_vld_q || pop;

    // Occupancy: output slot refills from skid first, otherwise from the input.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
        end else if (load_out) begin
            out_vld_q  <= skid_vld_q || push;
            skid_vld_q <= 1'b0;
        end else if (push) begin
            skid_vld_q <= 1'b1;
        end
    end

    // Payload registers; contents are don't-care while their valid is low.
    always_ff @(posedge clk) begin
        if (load_out) begin
            out_dat_q <= skid_vld_q ? skid_dat_q : udat;
        end
        if (!load_out && push) begin
            skid_dat_q <= udat;
        end
    end
endmodule

// File: rtl/prim_arb_rr.sv
// N-way round-robin arbiter with packet lock feeding one skid-buffered downstream channel.
module prim_arb_rr
    import prim_arb_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    prim_arb_rr_if.slave bus
);
    localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SBW = WIDTH + IDW + 1;

    arb_state_e       state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   owner_q, owner_d;
    logic [IDW-1:0]   win;
    logic [IDW-1:0]   gnt;
    logic             gnt_act;
    logic [N-1:0]     cand;
    logic [N-1:0]     urdy;
    logic [WIDTH-1:0] gnt_dat;
    logic             sb_uvld;
    logic             sb_urdy;
    logic [SBW-1:0]   sb_udat;
    logic             sb_dvld;
    logic [SBW-1:0]   sb_ddat;

    // Id following id, wrapping at N-1 (constant 0 when N=1).
    function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
        return (id == IDW'(N - 1)) ? '0 : id + IDW'(1);
    endfunction

    assign cand = bus.uvld_i & bus.en_i;
    assign win  = IDW'(rr_pick(ARB_MAX_N'(cand), ARB_IDX_W'(ptr_q), (ARB_IDX_W + 1)'(N)));

    // Grant selection and lock/pointer update; an offered but unaccepted grant locks so it cannot be stolen.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        gnt     = owner_q;
        gnt_act = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (|cand) begin
                    gnt     = win;
                    gnt_act = 1'b1;
                    if (sb_urdy && bus.ulast_i[win]) begin
                        ptr_d = next_id(win);
                    end else begin
                        state_d = ARB_LOCKED;
                        owner_d = win;
                    end
                end
            end
            ARB_LOCKED: begin
                gnt     = owner_q;
                gnt_act = 1'b1;
                if (sb_urdy && bus.uvld_i[owner_q] && bus.ulast_i[owner_q]) begin
                    state_d = ARB_IDLE;
                    ptr_d   = next_id(owner_q);
                end
            end
        endcase
    end

    // Arbitration state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    assign urdy    = gnt_act ? ((N'(1) << gnt) & {N{sb_urdy}}) : '0;
    assign gnt_dat = bus.udat_i[32'(gnt) * WIDTH +: WIDTH];
    assign sb_uvld = |(urdy & bus.uvld_i);
    assign sb_udat = {bus.ulast_i[gnt], gnt, gnt_dat};

    prim_skidbuf #(.WIDTH(SBW)) u_skid (
        .clk   (clk),
        .reset (reset),
        .stall (bus.dstall_i),
        .uvld  (sb_uvld),
        .udat  (sb_udat),
        .urdy  (sb_urdy),
        .dvld  (sb_dvld),
        .ddat  (sb_ddat),
        .drdy  (bus.drdy_i)
    );

    assign bus.urdy_o = urdy;
    assign bus.dvld_o = sb_dvld;
    assign {bus.dlast_o, bus.dsel_o, bus.ddat_o} = sb_ddat;
endmodule

// File: tb/tb_prim_arb_rr.sv
// Randomized and directed bench for prim_arb_rr against a queue-based reference model.
module tb_prim_arb_rr;
    localparam int unsigned N     = 4;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned IDW   = (N > 1) ? $clog2(N) : 1;

    typedef struct packed {
        logic             last;
        logic [WIDTH-1:0] data;
    } src_beat_t;

    typedef struct packed {
        logic             last;
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] data;
    } out_beat_t;

    logic clk;
    logic reset;

    prim_arb_rr_if #(.N(N), .WIDTH(WIDTH)) bus ();

    prim_arb_rr #(.N(N), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus knobs and per-requester packet sources.
    logic [N-1:0] en;
    logic         drdy;
    logic         dstall;
    bit           gaps;
    logic [N-1:0] off;
    src_beat_t    beatq[N][$];

    // Reference model: arbitration state plus the contents of the downstream buffer.
    bit           m_locked;
    int           m_owner;
    int           m_ptr;
    out_beat_t    m_q[$];
    out_beat_t    dlog[$];

    int unsigned  n_checks;
    int unsigned  n_pass;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic push_beat(input int r, input logic [WIDTH-1:0] d, input logic l);
        src_beat_t b;
        b.last = l;
        b.data = d;
        beatq[r].push_back(b);
    endtask

    task automatic clear_sources();
        for (int r = 0; r < N; r++) beatq[r].delete();
        off = '0;
    endtask

    // One clock cycle: drive, compare DUT with model, advance model and sources.
    task automatic step();
        logic [N-1:0]       uv, ul, cand, exp_urdy;
        logic [N*WIDTH-1:0] ud;
        int                 g;
        bit                 gv, sb_rdy, exp_dvld, ubeat;
        out_beat_t          ob;
        @(negedge clk);
        uv = '0; ul = '0; ud = '0;
        for (int i = 0; i < N; i++) begin
            if (!off[i] && beatq[i].size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) off[i] = 1'b1;
            if (off[i]) begin
                uv[i] = 1'b1;
                ul[i] = beatq[i][0].last;
                ud[i*WIDTH +: WIDTH] = beatq[i][0].data;
            end
        end
        bus.uvld_i   = uv;
        bus.ulast_i  = ul;
        bus.udat_i   = ud;
        bus.en_i     = en;
        bus.drdy_i   = drdy;
        bus.dstall_i = dstall;
        #1;
        cand   = uv & en;
        gv     = 1'b0;
        g      = 0;
        sb_rdy = !reset && (m_q.size() < 2);
        if (!reset) begin
            if (m_locked) begin
                gv = 1'b1;
                g  = m_owner;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (m_ptr + k) % N;
                    if (!gv && cand[idx]) begin
                        gv = 1'b1;
                        g  = idx;
                    end
                end
            end
        end
        exp_urdy = (gv && sb_rdy) ? (N'(1) << g) : '0;
        exp_dvld = !reset && (m_q.size() > 0) && !dstall;
        check("urdy", 64'(bus.urdy_o), 64'(exp_urdy));
        check("dvld", 64'(bus.dvld_o), 64'(exp_dvld));
        if (exp_dvld && bus.dvld_o) begin
            check("ddat",  64'(bus.ddat_o),  64'(m_q[0].data));
            check("dlast", 64'(bus.dlast_o), 64'(m_q[0].last));
            check("dsel",  64'(bus.dsel_o),  64'(m_q[0].id));
        end
        if (bus.dvld_o && drdy) begin
            ob.last = bus.dlast_o;
            ob.id   = bus.dsel_o;
            ob.data = bus.ddat_o;
            dlog.push_back(ob);
        end
        if (reset) begin
            m_q.delete();
            m_locked = 1'b0;
            m_ptr    = 0;
            m_owner  = 0;
        end else begin
            if (exp_dvld && drdy) void'(m_q.pop_front());
            ubeat = gv && sb_rdy && uv[g];
            if (ubeat) begin
                ob.last = ul[g];
                ob.id   = IDW'(g);
                ob.data = beatq[g][0].data;
                m_q.push_back(ob);
                if (ul[g]) begin
                    m_locked = 1'b0;
                    m_ptr    = (g + 1) % N;
                end else begin
                    m_locked = 1'b1;
                    m_owner  = g;
                end
                void'(beatq[g].pop_front());
                off[g] = 1'b0;
            end else if (gv) begin
                m_locked = 1'b1;
                m_owner  = g;
            end
        end
    endtask

    function automatic bit all_idle();
        bit idle;
        idle = (m_q.size() == 0);
        for (int r = 0; r < N; r++) if (beatq[r].size() > 0) idle = 1'b0;
        return idle;
    endfunction

    task automatic drain(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (all_idle()) begin
                done = 1'b1;
                break;
            end
            step();
        end
        check(name, 64'(done), 64'(1));
    endtask

    task automatic log_is(input string name, input int idx, input int sel, input logic [WIDTH-1:0] d);
        if (idx >= dlog.size()) begin
            check({name, "_len"}, 64'(dlog.size()), 64'(idx + 1));
        end else begin
            check({name, "_sel"}, 64'(dlog[idx].id),   64'(sel));
            check({name, "_dat"}, 64'(dlog[idx].data), 64'(d));
        end
    endtask

    initial begin
        bit hit;
        n_checks = 0;
        n_pass   = 0;
        en = '1; drdy = 1'b1; dstall = 1'b0; gaps = 1'b0; off = '0;
        m_locked = 1'b0; m_owner = 0; m_ptr = 0;
        bus.en_i = '0; bus.uvld_i = '0; bus.udat_i = '0; bus.ulast_i = '0;
        bus.drdy_i = 1'b0; bus.dstall_i = 1'b0;
        reset = 1'b1;
        repeat (3) step();
        check("rst_urdy", 64'(bus.urdy_o), 64'(0));
        check("rst_dvld", 64'(bus.dvld_o), 64'(0));
        reset = 1'b0;

        // All four requesters with single-beat packets: strict rotation from id 0.
        for (int r = 0; r < N; r++)
            for (int k = 0; k < 2; k++)
                push_beat(r, 32'hA000_0000 | WIDTH'(r << 8) | WIDTH'(k), 1'b1);
        drain("t1_drain", 200);
        check("t1_count", 64'(dlog.size()), 64'(8));
        log_is("t1_0", 0, 0, 32'hA000_0000);
        log_is("t1_1", 1, 1, 32'hA000_0100);
        log_is("t1_2", 2, 2, 32'hA000_0200);
        log_is("t1_3", 3, 3, 32'hA000_0300);
        log_is("t1_4", 4, 0, 32'hA000_0001);

        // Three-beat packet from req 1 is not interrupted by req 2.
        dlog.delete();
        push_beat(1, 32'hB1, 1'b0);
        push_beat(1, 32'hB2, 1'b0);
        push_beat(1, 32'hB3, 1'b1);
        step();
        push_beat(2, 32'hC1, 1'b1);
        drain("t2_drain", 100);
        log_is("t2_0", 0, 1, 32'hB1);
        log_is("t2_1", 1, 1, 32'hB2);
        log_is("t2_2", 2, 1, 32'hB3);
        log_is("t2_3", 3, 2, 32'hC1);

        // Downstream not ready: req 0 keeps its place, req 3 follows.
        dlog.delete();
        drdy = 1'b0;
        push_beat(0, 32'hD0, 1'b1);
        step();
        push_beat(3, 32'hE0, 1'b1);
        repeat (4) step();
        check("t3_held", 64'(dlog.size()), 64'(0));
        drdy = 1'b1;
        drain("t3_drain", 100);
        log_is("t3_0", 0, 0, 32'hD0);
        log_is("t3_1", 1, 3, 32'hE0);

        // Stall with everyone valid: buffer fills, then all data comes out once in order.
        dlog.delete();
        dstall = 1'b1;
        for (int k = 0; k < 3; k++)
            for (int r = 0; r < N; r++)
                push_beat(r, 32'h4000_0000 | WIDTH'(r << 4) | WIDTH'(k), 1'b1);
        repeat (5) step();
        check("t4_urdy_full", 64'(bus.urdy_o), 64'(0));
        check("t4_nobeat", 64'(dlog.size()), 64'(0));
        dstall = 1'b0;
        drain("t4_drain", 200);
        check("t4_count", 64'(dlog.size()), 64'(12));
        for (int j = 0; j < 12; j++)
            log_is("t4", j, j % 4, 32'h4000_0000 | WIDTH'((j % 4) << 4) | WIDTH'(j / 4));

        // Enable mask 1010; dropping en[1] mid-packet still finishes req 1.
        dlog.delete();
        en = 4'b1010;
        push_beat(0, 32'h50, 1'b1);
        push_beat(2, 32'h52, 1'b1);
        push_beat(1, 32'hF0, 1'b1);
        push_beat(1, 32'hF1, 1'b0);
        push_beat(1, 32'hF2, 1'b1);
        for (int k = 0; k < 3; k++) push_beat(3, 32'h60 + WIDTH'(k), 1'b1);
        hit = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (beatq[1].size() <= 1) begin
                hit = 1'b1;
                break;
            end
            step();
        end
        check("t5_midpkt", 64'(hit), 64'(1));
        en = 4'b1000;
        repeat (6) step();
        en = '1;
        drain("t5_drain", 100);
        log_is("t5_0", 0, 1, 32'hF0);
        log_is("t5_1", 1, 3, 32'h60);
        log_is("t5_2", 2, 1, 32'hF1);
        log_is("t5_3", 3, 1, 32'hF2);
        log_is("t5_4", 4, 3, 32'h61);
        log_is("t5_5", 5, 3, 32'h62);
        log_is("t5_6", 6, 0, 32'h50);
        log_is("t5_7", 7, 2, 32'h52);

        // Reset in the middle of req 2's packet.
        push_beat(2, 32'h70, 1'b0);
        push_beat(2, 32'h71, 1'b0);
        push_beat(2, 32'h72, 1'b1);
        hit = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (beatq[2].size() <= 2) begin
                hit = 1'b1;
                break;
            end
            step();
        end
        check("t6_midpkt", 64'(hit), 64'(1));
        reset = 1'b1;
        step();
        check("t6_rst_urdy", 64'(bus.urdy_o), 64'(0));
        check("t6_rst_dvld", 64'(bus.dvld_o), 64'(0));
        clear_sources();
        step();
        check("t6_rst_urdy2", 64'(bus.urdy_o), 64'(0));
        check("t6_rst_dvld2", 64'(bus.dvld_o), 64'(0));
        reset = 1'b0;
        dlog.delete();
        push_beat(3, 32'h83, 1'b1);
        push_beat(1, 32'h81, 1'b1);
        drain("t6_drain", 100);
        check("t6_count", 64'(dlog.size()), 64'(2));
        log_is("t6_0", 0, 1, 32'h81);
        log_is("t6_1", 1, 3, 32'h83);

        // Random traffic: packet lengths, gaps, enables, back-pressure, stalls, one reset.
        dlog.delete();
        gaps = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int r = 0; r < N; r++) begin
                if (beatq[r].size() == 0 && $urandom_range(0, 7) == 0) begin
                    int len;
                    len = int'($urandom_range(1, 4));
                    for (int b = 0; b < len; b++) push_beat(r, WIDTH'($urandom), b == len - 1);
                end
            end
            if ($urandom_range(0, 15) == 0) en = N'($urandom);
            drdy   = $urandom_range(0, 3) != 0;
            dstall = $urandom_range(0, 15) == 0;
            reset  = (cyc == 1500) || (cyc == 1501);
            step();
        end
        reset = 1'b0; gaps = 1'b0; en = '1; drdy = 1'b1; dstall = 1'b0;
        drain("t7_drain", 500);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
